// File: rtl/hack_memory_map_if.sv
// CPU data-memory bus of the Hack computer.
// Signals:
//   in      - CPU write data
//   load    - CPU write enable
//   address - CPU word address (32K-word space)
//   out     - CPU read data, combinational from address and stored state
// Modports: master = CPU side, slave = memory side.
interface hack_memory_map_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] in;
    logic             load;
    logic [14:0]      address;
    logic [WIDTH-1:0] out;

    modport master (
        output in,
        output load,
        output address,
        input  out
    );

    modport slave (
        input  in,
        input  load,
        input  address,
        output out
    );
endinterface

// File: rtl/hack_memory_map.sv
// Hack computer data memory: 16K RAM, 8K screen buffer, read-only keyboard
// register, plus a registered read-only scan port into the screen buffer.
// Ports:
//   clk, reset - single clock, synchronous active-high reset
//   bus        - CPU bus (in, load, address, out), slave side
//   key_in     - keyboard scan code, 0 = no key
//   scan_addr  - display controller screen word address
//   scan_data  - screen word at scan_addr, one cycle later
module hack_memory_map #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    hack_memory_map_if.slave     bus,
    input  logic [WIDTH-1:0]     key_in,
    input  logic [12:0]          scan_addr,
    output logic [WIDTH-1:0]     scan_data
);
    localparam int unsigned RAM_WORDS = 16384;
    localparam int unsigned SCR_WORDS = 8192;

    logic [WIDTH-1:0] ram    [RAM_WORDS];
    logic [WIDTH-1:0] screen [SCR_WORDS];
    logic [WIDTH-1:0] kbd_reg;

    logic [1:0] sel_c;
    logic [3:0] wr_c;
    logic       ram_we_c;
    logic       scr_we_c;

    // One-hot load steering on address[14:13]; reset masks every write.
    always_comb begin
        sel_c    = bus.address[14:13];
        wr_c     = bus.load ? 4'(4'd1 << sel_c) : 4'd0;
        ram_we_c = (wr_c[0] | wr_c[1]) & ~reset;
        scr_we_c = wr_c[2] & ~reset;
    end

    // RAM store; contents are not cleared by reset.
    always_ff @(posedge clk) begin
        if (ram_we_c) begin
            ram[bus.address[13:0]] <= bus.in;
        end
    end

    // Screen store: one write port here, two read ports (CPU mux, scan port).
    always_ff @(posedge clk) begin
        if (scr_we_c) begin
            screen[bus.address[12:0]] <= bus.in;
        end
    end

    // Scan port reads the pre-edge contents, so a coincident write to the
    // same word shows up one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_data <= '0;
        end else begin
            scan_data <= screen[scan_addr];
        end
    end

    // Keyboard register samples key_in every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            kbd_reg <= '0;
        end else begin
            kbd_reg <= key_in;
        end
    end

    // CPU read mux; only 0x6000 is mapped in the top quarter.
    always_comb begin
        bus.out = '0;
        case (sel_c)
            2'd0, 2'd1: bus.out = ram[bus.address[13:0]];
            2'd2:       bus.out = screen[bus.address[12:0]];
            default:    bus.out = (bus.address[12:0] == 13'd0) ? kbd_reg : '0;
        endcase
    end
endmodule

// File: tb/tb_hack_memory_map.sv
module tb_hack_memory_map;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] key_in;
    logic [12:0] scan_addr;
    logic [15:0] scan_data;

    int n_tests = 0;
    int n_fail  = 0;

    hack_memory_map_if #(.WIDTH(16)) bus ();

    hack_memory_map #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .key_in    (key_in),
        .scan_addr (scan_addr),
        .scan_data (scan_data)
    );

    always #5 clk = ~clk;

    // Reference model: plain arrays indexed by address arithmetic.
    logic [15:0] ram_m [16384];
    bit          ram_v [16384];
    logic [15:0] scr_m [8192];
    bit          scr_v [8192];
    logic [15:0] kbd_m  = '0;
    bit          kbd_v  = 1'b0;
    logic [15:0] scan_m = '0;
    bit          scan_v = 1'b0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_read(input logic [14:0] a, output bit valid);
        int ia;
        ia = int'(a);
        valid = 1'b1;
        if (ia < 16384) begin
            valid = ram_v[ia];
            return ram_m[ia];
        end else if (ia < 24576) begin
            valid = scr_v[ia - 16384];
            return scr_m[ia - 16384];
        end else if (ia == 24576) begin
            valid = kbd_v;
            return kbd_m;
        end
        return 16'h0000;
    endfunction

    // One clock cycle: drive, check combinational out, clock, update model,
    // check scan_data. Starts and ends with clk low.
    task automatic do_cycle(input string tag, input bit rst, input bit ld,
                            input logic [14:0] a, input logic [15:0] d,
                            input logic [15:0] k, input logic [12:0] s);
        logic [15:0] exp;
        bit          v;
        int          ia;
        reset       = rst;
        bus.load    = ld;
        bus.address = a;
        bus.in      = d;
        key_in      = k;
        scan_addr   = s;
        #1;
        exp = model_read(a, v);
        if (v) check({tag, ".out"}, bus.out, exp);
        @(posedge clk);
        ia = int'(a);
        if (rst) begin
            kbd_m  = '0;
            kbd_v  = 1'b1;
            scan_m = '0;
            scan_v = 1'b1;
        end else begin
            scan_m = scr_m[int'(s)];
            scan_v = scr_v[int'(s)];
            if (ld && ia < 16384) begin
                ram_m[ia] = d;
                ram_v[ia] = 1'b1;
            end else if (ld && ia < 24576) begin
                scr_m[ia - 16384] = d;
                scr_v[ia - 16384] = 1'b1;
            end
            kbd_m = k;
            kbd_v = 1'b1;
        end
        @(negedge clk);
        if (scan_v) check({tag, ".scan"}, scan_data, scan_m);
    endtask

    // Read-only cycle.
    task automatic rd(input string tag, input logic [14:0] a, input logic [15:0] k,
                      input logic [12:0] s);
        do_cycle(tag, 1'b0, 1'b0, a, 16'h0000, k, s);
    endtask

    // Write cycle.
    task automatic wr(input string tag, input logic [14:0] a, input logic [15:0] d);
        do_cycle(tag, 1'b0, 1'b1, a, d, 16'h0000, 13'h0000);
    endtask

    initial begin
        logic [14:0] a;
        logic [12:0] s;
        logic [15:0] k;
        int          kind;
        n_tests = 0;
        n_fail  = 0;

        // Reset state: scan and keyboard both zero.
        do_cycle("reset", 1'b1, 1'b0, 15'h6000, 16'h0, 16'h0055, 13'h0);
        check("reset.scan_data", scan_data, 16'h0000);
        rd("reset.kbd", 15'h6000, 16'h0000, 13'h0);
        check("reset.kbd_out", bus.out, 16'h0000);

        // RAM write/read; screen word 5 seeded so 0x4005 is comparable.
        wr("ram.w5", 15'h4005, 16'h5A5A);
        wr("ram.w0", 15'h0005, 16'h1234);
        wr("ram.w1", 15'h3FFF, 16'hBEEF);
        rd("ram.r0", 15'h0005, 16'h0, 13'h0);
        rd("ram.r1", 15'h3FFF, 16'h0, 13'h0);
        rd("ram.alias", 15'h4005, 16'h0, 13'h0);

        // Screen write then scan and CPU read.
        wr("scr.w", 15'h4010, 16'hA5A5);
        rd("scr.scan", 15'h4010, 16'h0, 13'h010);
        check("scr.scan_data", scan_data, 16'hA5A5);

        // Keyboard: one-cycle latency, writes discarded, zero clears.
        rd("kbd.apply", 15'h0005, 16'h0041, 13'h0);
        do_cycle("kbd.wr", 1'b0, 1'b1, 15'h6000, 16'hFFFF, 16'h0041, 13'h0);
        rd("kbd.keep", 15'h6000, 16'h0000, 13'h0);
        rd("kbd.zero", 15'h6000, 16'h0000, 13'h0);

        // Unmapped writes are ignored and read back zero.
        wr("unm.p0", 15'h0001, 16'h0A01);
        wr("unm.p1", 15'h1FFF, 16'h0A02);
        wr("unm.p2", 15'h4001, 16'h0A03);
        wr("unm.p3", 15'h5FFF, 16'h0A04);
        wr("unm.w0", 15'h6001, 16'h7777);
        wr("unm.w1", 15'h7FFF, 16'h7777);
        rd("unm.r0", 15'h6001, 16'h0, 13'h0);
        rd("unm.r1", 15'h7FFF, 16'h0, 13'h0);
        rd("unm.c0", 15'h0001, 16'h0, 13'h0);
        rd("unm.c1", 15'h1FFF, 16'h0, 13'h0);
        rd("unm.c2", 15'h4001, 16'h0, 13'h0);
        rd("unm.c3", 15'h5FFF, 16'h0, 13'h0);

        // Scan collision: old value first, new value one cycle later.
        wr("col.seed", 15'h4020, 16'h1111);
        do_cycle("col.hit", 1'b0, 1'b1, 15'h4020, 16'h2222, 16'h0, 13'h020);
        check("col.old", scan_data, 16'h1111);
        rd("col.next", 15'h4020, 16'h0, 13'h020);
        check("col.new", scan_data, 16'h2222);

        // Mid-stream reset kills coincident write and scan result.
        wr("rst.seed", 15'h0007, 16'h0101);
        rd("rst.pre", 15'h6000, 16'h0033, 13'h010);
        do_cycle("rst.hit", 1'b1, 1'b1, 15'h0007, 16'h9999, 16'h0033, 13'h010);
        check("rst.scan_zero", scan_data, 16'h0000);
        rd("rst.kbd", 15'h6000, 16'h0000, 13'h010);
        check("rst.kbd_zero", bus.out, 16'h0000);
        rd("rst.word", 15'h0007, 16'h0000, 13'h010);
        check("rst.word_kept", bus.out, 16'h0101);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            kind = int'($urandom_range(0, 9));
            if (kind <= 3)
                a = ($urandom_range(0, 1) == 0) ? 15'($urandom_range(0, 31))
                                                : 15'(16383 - $urandom_range(0, 31));
            else if (kind <= 6)
                a = ($urandom_range(0, 1) == 0) ? 15'(16384 + $urandom_range(0, 31))
                                                : 15'(24575 - $urandom_range(0, 31));
            else if (kind == 7)
                a = 15'h6000;
            else
                a = 15'(24577 + $urandom_range(0, 8190));
            s = ($urandom_range(0, 1) == 0) ? 13'($urandom_range(0, 31))
                                            : 13'(8191 - $urandom_range(0, 31));
            k = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom_range(1, 65535));
            do_cycle("rand", ($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
                     a, 16'($urandom), k, s);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
